// File: rtl/kda_output_data_channel_sized.sv
// kda_output_data_channel_sized
// Wide-to-narrow output channel for KDA results. One in_width_p-bit message
// is accepted per handshake and emitted as (len_i + 1) words of out_width_p
// bits. A new message may be accepted in the same cycle that the last word
// of the previous one is consumed, so back-to-back messages have no bubbles.
//
// Optional build macro: KDA_OUTPUT_DATA_CHANNEL_PERF_EN
//   When defined, the channel adds three saturating 32-bit performance
//   counters: stall_cnt_o, msg_cnt_o and word_cnt_o.
//   When undefined, these ports do not exist.
//   The datapath is identical in both builds.
//
// Parameter constraints: in_width_p must be a multiple of out_width_p, and
// els_lp must be at least 2.

`timescale 1ns/1ps

module kda_output_data_channel_sized #(
  parameter int in_width_p  = 1024,
  parameter int out_width_p = 64,
  parameter bit msb_first_p = 1'b0,
  localparam int els_lp     = in_width_p / out_width_p,
  localparam int lg_els_lp  = $clog2(els_lp)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,

  input  logic [in_width_p-1:0]  data_i,
  input  logic [lg_els_lp-1:0]   len_i,
  input  logic                   v_i,
  output logic                   yumi_o,

  output logic [out_width_p-1:0] data_o,
  output logic                   v_o,
  output logic                   last_o,
  input  logic                   yumi_i
`ifdef KDA_OUTPUT_DATA_CHANNEL_PERF_EN
  ,
  output logic [31:0]            stall_cnt_o,
  output logic [31:0]            msg_cnt_o,
  output logic [31:0]            word_cnt_o
`endif
);

  localparam logic [lg_els_lp-1:0] max_idx_lp = lg_els_lp'(els_lp - 1);
  localparam logic [lg_els_lp-1:0] one_lp     = lg_els_lp'(1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                 state_r, state_n;
  logic [in_width_p-1:0]  msg_r;
  logic [lg_els_lp-1:0]   len_r;
  logic [lg_els_lp-1:0]   idx_r, idx_n;
  logic                   load;
  logic                   is_last;
  logic [lg_els_lp-1:0]   word_sel;
  logic [out_width_p-1:0] words [els_lp];

  // The current word is the final one of the message when idx_r reaches len_r.
  assign is_last = (idx_r == len_r);

  // Outputs are forced low during reset so a partly sent message is never visible.
  assign v_o    = (state_r == SEND) && !reset_i;
  assign last_o = v_o && is_last;

  // Split the stored message into word slots and pick the slot for idx_r.
  // The slot order depends on msb_first_p.
  always_comb begin
    for (int i = 0; i < els_lp; i++) begin
      words[i] = msg_r[i*out_width_p +: out_width_p];
    end
    word_sel = msb_first_p ? (max_idx_lp - idx_r) : idx_r;
    data_o   = words[word_sel];
  end

  // Compute the next state, the word index and the input handshake.
  // yumi_o depends only on control signals and never on data_i.
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    load    = 1'b0;
    yumi_o  = 1'b0;
    case (state_r)
      IDLE: begin
        if (v_i) begin
          yumi_o  = 1'b1;
          load    = 1'b1;
          idx_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (yumi_i) begin
          if (is_last) begin
            if (v_i) begin
              yumi_o = 1'b1;
              load   = 1'b1;
              idx_n  = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            idx_n = idx_r + one_lp;
          end
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
    if (reset_i) begin
      yumi_o = 1'b0;
      load   = 1'b0;
    end
  end

  // Register the control state. Reset returns the channel to IDLE at word 0.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      idx_r   <= '0;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
    end
  end

  // Capture the message and its length whenever a new message is accepted.
  always_ff @(posedge clk_i) begin
    if (load) begin
      msg_r <= data_i;
      len_r <= len_i;
    end
  end

`ifdef KDA_OUTPUT_DATA_CHANNEL_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] msg_cnt_r;
  logic [31:0] word_cnt_r;

  // Saturating event counters.
  // Each counter is cleared by reset and becomes visible the cycle after its event.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_r <= '0;
      msg_cnt_r   <= '0;
      word_cnt_r  <= '0;
    end else begin
      if (v_o && !yumi_i && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (last_o && yumi_i && (msg_cnt_r != 32'hFFFF_FFFF)) begin
        msg_cnt_r <= msg_cnt_r + 32'd1;
      end
      if (v_o && yumi_i && (word_cnt_r != 32'hFFFF_FFFF)) begin
        word_cnt_r <= word_cnt_r + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_r;
  assign msg_cnt_o   = msg_cnt_r;
  assign word_cnt_o  = word_cnt_r;
`endif

  // A consumer must not take a word while none is being offered.
  // The hardware ignores such a request, but simulation reports it.
  illegal_yumi_a : assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));

endmodule

// File: tb/tb_kda_output_data_channel_sized.sv
// tb_kda_output_data_channel_sized
// Drives two channel instances, one LSB-first and one MSB-first, with the
// same handshake stimulus. A queue model of the expected word stream is
// compared against both instances on every cycle.

`timescale 1ns/1ps

module tb_kda_output_data_channel_sized;

  localparam int IN_W  = 1024;
  localparam int OUT_W = 64;
  localparam int ELS   = IN_W / OUT_W;

  logic            clk_i = 1'b0;
  logic            reset_i = 1'b1;
  logic [IN_W-1:0] data_i = '0;
  logic [3:0]      len_i = '0;
  logic            v_i = 1'b0;
  logic            yumi_i = 1'b0;

  logic             yumi_o0, yumi_o1;
  logic [OUT_W-1:0] data_o0, data_o1;
  logic             v_o0, v_o1, last_o0, last_o1;
`ifdef KDA_OUTPUT_DATA_CHANNEL_PERF_EN
  logic [31:0] stall_cnt0, msg_cnt0, word_cnt0;
  logic [31:0] stall_cnt1, msg_cnt1, word_cnt1;
`endif

  kda_output_data_channel_sized #(.in_width_p(IN_W), .out_width_p(OUT_W), .msb_first_p(1'b0)) dut_lsb (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .len_i(len_i), .v_i(v_i), .yumi_o(yumi_o0),
    .data_o(data_o0), .v_o(v_o0), .last_o(last_o0), .yumi_i(yumi_i)
`ifdef KDA_OUTPUT_DATA_CHANNEL_PERF_EN
    , .stall_cnt_o(stall_cnt0), .msg_cnt_o(msg_cnt0), .word_cnt_o(word_cnt0)
`endif
  );

  kda_output_data_channel_sized #(.in_width_p(IN_W), .out_width_p(OUT_W), .msb_first_p(1'b1)) dut_msb (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .len_i(len_i), .v_i(v_i), .yumi_o(yumi_o1),
    .data_o(data_o1), .v_o(v_o1), .last_o(last_o1), .yumi_i(yumi_i)
`ifdef KDA_OUTPUT_DATA_CHANNEL_PERF_EN
    , .stall_cnt_o(stall_cnt1), .msg_cnt_o(msg_cnt1), .word_cnt_o(word_cnt1)
`endif
  );

  always #5 clk_i = ~clk_i;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Model state: the words still to be emitted, in LSB-first and MSB-first order.
  logic [63:0] q_lsb[$];
  logic [63:0] q_msb[$];
  logic        exp_v = 1'b0;
  logic        exp_yumi = 1'b0;
  logic        ready_en = 1'b1;

  // Log of the words the model says were consumed.
  logic [63:0] cap_lsb[$];
  logic [63:0] cap_msb[$];
  bit          cap_last[$];
  int          cap_cyc[$];
  int          stall_seen = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] mkMsg(input int base);
    logic [IN_W-1:0] m;
    for (int k = 0; k < ELS; k++) m[k*OUT_W +: OUT_W] = 64'(base + k);
    return m;
  endfunction

  // Compare the DUT outputs with the model at negedge+2.
  // At the following posedge, advance the model.
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      exp_v    = !reset_i && (q_lsb.size() != 0);
      exp_yumi = !reset_i && v_i && ((q_lsb.size() == 0) || (yumi_i && q_lsb.size() == 1));
      checkOutput("v_o_lsb", 64'(v_o0), 64'(exp_v));
      checkOutput("v_o_msb", 64'(v_o1), 64'(exp_v));
      checkOutput("yumi_o_lsb", 64'(yumi_o0), 64'(exp_yumi));
      checkOutput("yumi_o_msb", 64'(yumi_o1), 64'(exp_yumi));
      if (exp_v) begin
        checkOutput("data_o_lsb", data_o0, q_lsb[0]);
        checkOutput("data_o_msb", data_o1, q_msb[0]);
        checkOutput("last_o_lsb", 64'(last_o0), 64'(q_lsb.size() == 1));
        checkOutput("last_o_msb", 64'(last_o1), 64'(q_lsb.size() == 1));
        if (yumi_i) begin
          cap_lsb.push_back(q_lsb[0]);
          cap_msb.push_back(q_msb[0]);
          cap_last.push_back(q_lsb.size() == 1);
          cap_cyc.push_back(cyc);
        end else begin
          stall_seen++;
        end
      end
      @(posedge clk_i);
      if (reset_i) begin
        q_lsb.delete();
        q_msb.delete();
      end else begin
        if (exp_v && yumi_i) begin
          void'(q_lsb.pop_front());
          void'(q_msb.pop_front());
        end
        if (exp_yumi) begin
          for (int k = 0; k <= int'(len_i); k++) begin
            q_lsb.push_back(data_i[k*OUT_W +: OUT_W]);
            q_msb.push_back(data_i[(ELS-1-k)*OUT_W +: OUT_W]);
          end
        end
      end
      cyc++;
    end
  end

  // The consumer takes a word whenever one is expected and the bench allows it.
  initial begin
    forever begin
      @(negedge clk_i);
      #1;
      yumi_i = ready_en && !reset_i && (q_lsb.size() != 0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Offer a message and hold v_i until the model accepts it.
  // v_i is left high so the caller can chain the next message.
  task automatic applyStimulus(input logic [IN_W-1:0] d, input logic [3:0] len);
    int budget = 60;
    @(negedge clk_i);
    data_i = d;
    len_i  = len;
    v_i    = 1'b1;
    forever begin
      #3;
      if (exp_yumi) break;
      budget--;
      if (budget == 0) begin
        checkOutput("accept_timeout", 64'(0), 64'(1));
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic idleInput();
    @(negedge clk_i);
    v_i = 1'b0;
  endtask

  task automatic waitWords(input int n);
    int budget = 200;
    while (cap_lsb.size() < n && budget > 0) begin
      @(negedge clk_i);
      #4;
      budget--;
    end
    if (cap_lsb.size() < n) checkOutput("words_timeout", 64'(cap_lsb.size()), 64'(n));
  endtask

  task automatic clearLog();
    cap_lsb.delete();
    cap_msb.delete();
    cap_last.delete();
    cap_cyc.delete();
    stall_seen = 0;
  endtask

  task automatic resetPulse();
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  int acc;

  initial begin
    // Reset state: v_i is asserted, but yumi_o must stay low during reset.
    repeat (2) @(negedge clk_i);
    v_i = 1'b1;
    #3;
    checkOutput("reset_v_o", 64'(v_o0), 64'(0));
    checkOutput("reset_yumi_o", 64'(yumi_o0), 64'(0));
    checkOutput("reset_last_o", 64'(last_o0), 64'(0));
    @(negedge clk_i);
    v_i = 1'b0;
    reset_i = 1'b0;

    // Full 16-word message in both word orders.
    clearLog();
    applyStimulus(mkMsg('h1000), 4'd15);
    acc = cyc;
    checkOutput("t1_yumi_o", 64'(yumi_o0), 64'(1));
    idleInput();
    waitWords(16);
    checkOutput("t1_count", 64'(cap_lsb.size()), 64'(16));
    checkOutput("t1_first", cap_lsb[0], 64'h1000);
    checkOutput("t1_lastword", cap_lsb[15], 64'h100F);
    checkOutput("t1_last15", 64'(cap_last[15]), 64'(1));
    checkOutput("t1_last14", 64'(cap_last[14]), 64'(0));
    checkOutput("t1_cyc_first", 64'(cap_cyc[0]), 64'(acc + 1));
    checkOutput("t1_cyc_last", 64'(cap_cyc[15]), 64'(acc + 16));
    checkOutput("t5_msb_first", cap_msb[0], 64'h100F);
    checkOutput("t5_msb_last", cap_msb[15], 64'h1000);
    @(negedge clk_i);
    #3;
    checkOutput("t1_v_o_after", 64'(v_o0), 64'(0));

    // Short 4-word message.
    clearLog();
    applyStimulus(mkMsg('h1000), 4'd3);
    idleInput();
    waitWords(4);
    checkOutput("t2_count", 64'(cap_lsb.size()), 64'(4));
    checkOutput("t2_w3", cap_lsb[3], 64'h1003);
    checkOutput("t2_last3", 64'(cap_last[3]), 64'(1));
    checkOutput("t2_last2", 64'(cap_last[2]), 64'(0));
    @(negedge clk_i);
    #3;
    checkOutput("t2_idle", 64'(v_o0), 64'(0));

    // Two messages back to back with no bubble cycle between them.
    clearLog();
    applyStimulus(mkMsg('h1000), 4'd15);
    acc = cyc;
    applyStimulus(mkMsg('h2000), 4'd1);
    checkOutput("t3_chain_cyc", 64'(cyc), 64'(acc + 16));
    checkOutput("t3_chain_yumi", 64'(yumi_o0), 64'(1));
    idleInput();
    waitWords(18);
    checkOutput("t3_nogap", 64'(cap_cyc[17] - cap_cyc[0]), 64'(17));
    checkOutput("t3_cyc16", 64'(cap_cyc[15]), 64'(acc + 16));
    checkOutput("t3_cyc18", 64'(cap_cyc[17]), 64'(acc + 18));
    checkOutput("t3_last15", 64'(cap_last[15]), 64'(1));
    checkOutput("t3_last16", 64'(cap_last[16]), 64'(0));
    checkOutput("t3_last17", 64'(cap_last[17]), 64'(1));
    checkOutput("t3_w16", cap_lsb[16], 64'h2000);
    checkOutput("t3_w17", cap_lsb[17], 64'h2001);

    // Stall the consumer for 5 cycles while word 6 is presented.
    resetPulse();
    clearLog();
    applyStimulus(mkMsg('h1000), 4'd15);
    idleInput();
    waitWords(6);
    ready_en = 1'b0;
    repeat (5) @(negedge clk_i);
    #4;
    ready_en = 1'b1;
    waitWords(16);
    checkOutput("t4_stalls", 64'(stall_seen), 64'(5));
    checkOutput("t4_w6", cap_lsb[6], 64'h1006);
    checkOutput("t4_w7", cap_lsb[7], 64'h1007);
    checkOutput("t4_hold_len", 64'(cap_cyc[6] - cap_cyc[5]), 64'(6));
    @(negedge clk_i);
    #3;
`ifdef KDA_OUTPUT_DATA_CHANNEL_PERF_EN
    checkOutput("t4_stall_cnt", 64'(stall_cnt0), 64'(5));
    checkOutput("t4_word_cnt", 64'(word_cnt0), 64'(16));
    checkOutput("t4_msg_cnt", 64'(msg_cnt0), 64'(1));
`endif

    // Reset in the middle of a message: the old words are discarded.
    clearLog();
    applyStimulus(mkMsg('h1000), 4'd15);
    idleInput();
    waitWords(8);
    @(negedge clk_i);
    reset_i = 1'b1;
    data_i  = mkMsg('h3000);
    len_i   = 4'd2;
    v_i     = 1'b1;
    #3;
    checkOutput("t6_rst_v_o", 64'(v_o0), 64'(0));
    checkOutput("t6_rst_v_o_msb", 64'(v_o1), 64'(0));
    checkOutput("t6_rst_yumi_o", 64'(yumi_o0), 64'(0));
    @(negedge clk_i);
    reset_i = 1'b0;
    #3;
    checkOutput("t6_new_yumi_o", 64'(yumi_o0), 64'(1));
    idleInput();
    waitWords(11);
    checkOutput("t6_count", 64'(cap_lsb.size()), 64'(11));
    checkOutput("t6_w0", cap_lsb[8], 64'h3000);
    checkOutput("t6_w2", cap_lsb[10], 64'h3002);
    checkOutput("t6_last", 64'(cap_last[10]), 64'(1));
    repeat (3) @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
